// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
// Optional feature macro: BIT_SERIALIZER_PARITY_EN (appends an even-parity bit).
package bit_serializer_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Number of bit cycles in one frame for a given word width.
  function automatic int frame_len(input int data_w);
`ifdef BIT_SERIALIZER_PARITY_EN
    return data_w + 1;
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Load handshake and serial output bundle of the bit serializer.
interface bit_serializer_if #(
  parameter int DATA_W = 8
);
  localparam int IDX_W = $clog2(DATA_W + 2);

  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              bit_out;
  logic              bit_valid;
  logic              frame_done;
  logic [IDX_W-1:0]  bit_index;

  // Upstream producer / downstream consumer view.
  modport master (
    output load_valid, load_data,
    input  load_ready, bit_out, bit_valid, frame_done, bit_index
  );

  // Serializer view.
  modport slave (
    input  load_valid, load_data,
    output load_ready, bit_out, bit_valid, frame_done, bit_index
  );
endinterface

// File: rtl/bit_counter.sv
// Bit-position counter: clears to 0, counts while enabled, wraps at terminal.
module bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_terminal,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);
  logic [W-1:0] r_count;

  assign o_wrap  = i_enable && (r_count == i_terminal);
  assign o_count = r_count;

  // Clear has priority; otherwise advance or wrap back to zero.
  always_ff @(posedge clk) begin
    if (i_clear)       r_count <= '0;
    else if (i_enable) r_count <= o_wrap ? '0 : r_count + 1'b1;
  end
endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready load handshake.
// Optional feature macro: BIT_SERIALIZER_PARITY_EN (even-parity bit after data).
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MSB_FIRST = 1
) (
  input logic             clk,
  input logic             reset,
  bit_serializer_if.slave bus
);
  localparam int               FRAME_LEN = frame_len(DATA_W);
  localparam int               IDX_W     = $clog2(DATA_W + 2);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);

  ser_state_t        r_state;
  logic [DATA_W-1:0] r_shift;
  logic              w_shifting;
  logic              w_ready;
  logic              w_accept;
  logic              w_wrap;
  logic              w_data_bit;
  logic [IDX_W-1:0]  w_index;

  assign w_shifting = (r_state == SHIFT);
  assign w_ready    = !w_shifting || (w_index == LAST_IDX);
  assign w_accept   = bus.load_valid && w_ready && !reset;
  assign w_data_bit = (MSB_FIRST != 0) ? r_shift[DATA_W-1] : r_shift[0];

  // Counter restarts on every accepted word, which gives the bubble-free
  // back-to-back frame without a separate reload path.
  bit_counter #(.W(IDX_W)) u_bit_counter (
    .clk        (clk),
    .i_clear    (reset || w_accept),
    .i_enable   (w_shifting),
    .i_terminal (LAST_IDX),
    .o_count    (w_index),
    .o_wrap     (w_wrap)
  );

  // FSM and shift register: load on accept, shift each bit cycle, idle on wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_shift <= bus.load_data;
    end else if (w_wrap) begin
      r_state <= IDLE;
      r_shift <= '0;
    end else if (w_shifting) begin
      r_shift <= (MSB_FIRST != 0) ? {r_shift[DATA_W-2:0], 1'b0}
                                  : {1'b0, r_shift[DATA_W-1:1]};
    end
  end

`ifdef BIT_SERIALIZER_PARITY_EN
  logic r_parity;

  // Even parity of the accepted word, emitted after the data bits.
  always_ff @(posedge clk) begin
    if (reset)         r_parity <= 1'b0;
    else if (w_accept) r_parity <= ^bus.load_data;
  end

  assign bus.bit_out = w_shifting &&
                       ((w_index == IDX_W'(DATA_W)) ? r_parity : w_data_bit);
`else
  assign bus.bit_out = w_shifting && w_data_bit;
`endif

  assign bus.load_ready = w_ready;
  assign bus.bit_valid  = w_shifting;
  assign bus.frame_done = w_shifting && (w_index == LAST_IDX);
  assign bus.bit_index  = w_index;
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench: two serializers (MSB-first and LSB-first) share stimulus.
module tb_bit_serializer;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       lv;
  logic [7:0] ld;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  bit_serializer_if #(.DATA_W(8)) if0 ();
  bit_serializer_if #(.DATA_W(8)) if1 ();

  assign if0.load_valid = lv;
  assign if0.load_data  = ld;
  assign if1.load_valid = lv;
  assign if1.load_data  = ld;

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1)) dut_msb (
    .clk   (clk),
    .reset (rst),
    .bus   (if0)
  );

  bit_serializer #(.DATA_W(8), .MSB_FIRST(0)) dut_lsb (
    .clk   (clk),
    .reset (rst),
    .bus   (if1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_bit(input logic [7:0] d, input int i, input bit msb);
    if (i == 8) return int'(^d);
    return msb ? int'(d[7-i]) : int'(d[i]);
  endfunction

  // Both DUTs idle: waits one negedge and checks held outputs.
  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, "_valid0"}, int'(if0.bit_valid),  0);
    chk({tag, "_out0"},   int'(if0.bit_out),    0);
    chk({tag, "_done0"},  int'(if0.frame_done), 0);
    chk({tag, "_idx0"},   int'(if0.bit_index),  0);
    chk({tag, "_rdy0"},   int'(if0.load_ready), 1);
    chk({tag, "_valid1"}, int'(if1.bit_valid),  0);
    chk({tag, "_out1"},   int'(if1.bit_out),    0);
    chk({tag, "_rdy1"},   int'(if1.load_ready), 1);
  endtask

  // Checks one frame of word d, accepted at the preceding posedge.
  // chain: present nd during the last bit; poke: hold load_valid with 8'hFF
  // from bit 2 on; abort: assert reset after checking that bit (-1 = never).
  task automatic frame(input logic [7:0] d, input bit chain, input logic [7:0] nd,
                       input bit poke, input int abort);
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      chk($sformatf("f%02h_b%0d_valid0", d, i), int'(if0.bit_valid), 1);
      chk($sformatf("f%02h_b%0d_out0", d, i),   int'(if0.bit_out),   exp_bit(d, i, 1'b1));
      chk($sformatf("f%02h_b%0d_idx0", d, i),   int'(if0.bit_index), i);
      chk($sformatf("f%02h_b%0d_done0", d, i),  int'(if0.frame_done), (i == FL-1) ? 1 : 0);
      chk($sformatf("f%02h_b%0d_rdy0", d, i),   int'(if0.load_ready), (i == FL-1) ? 1 : 0);
      chk($sformatf("f%02h_b%0d_valid1", d, i), int'(if1.bit_valid), 1);
      chk($sformatf("f%02h_b%0d_out1", d, i),   int'(if1.bit_out),   exp_bit(d, i, 1'b0));
      chk($sformatf("f%02h_b%0d_idx1", d, i),   int'(if1.bit_index), i);
      chk($sformatf("f%02h_b%0d_done1", d, i),  int'(if1.frame_done), (i == FL-1) ? 1 : 0);
      if (i == abort) begin
        rst = 1'b1;
        lv  = 1'b1;
        ld  = 8'hFF;
        break;
      end
      if (i == FL-1) begin
        lv = chain;
        ld = nd;
      end else if (poke && i >= 2) begin
        lv = 1'b1;
        ld = 8'hFF;
      end else begin
        lv = 1'b0;
        ld = 8'h5A;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    lv  = 1'b0;
    ld  = 8'h00;
    repeat (2) @(posedge clk);
    chk_idle("reset");
    rst = 1'b0;

    // Single word, then back to idle.
    lv = 1'b1; ld = 8'hB4;
    frame(8'hB4, 1'b0, 8'h00, 1'b0, -1);
    chk_idle("after_b4");

    // Back-to-back frames with the second word offered on the last bit.
    lv = 1'b1; ld = 8'hB4;
    frame(8'hB4, 1'b1, 8'h0F, 1'b0, -1);
    frame(8'h0F, 1'b0, 8'h00, 1'b0, -1);
    chk_idle("after_b2b");

    // Mid-frame load_valid is held off until the last bit cycle.
    lv = 1'b1; ld = 8'h01;
    frame(8'h01, 1'b1, 8'hFF, 1'b1, -1);
    frame(8'hFF, 1'b0, 8'h00, 1'b0, -1);
    chk_idle("after_poke");

    // Reset at bit 3 aborts the frame; load_valid during reset is ignored.
    lv = 1'b1; ld = 8'hB4;
    frame(8'hB4, 1'b0, 8'h00, 1'b0, 3);
    chk_idle("abort_a");
    chk_idle("abort_b");
    rst = 1'b0;
    lv = 1'b1; ld = 8'h0F;
    frame(8'h0F, 1'b0, 8'h00, 1'b0, -1);
    chk_idle("after_abort");

    // Odd-weight word (parity 1 when the parity bit is present).
    lv = 1'b1; ld = 8'h07;
    frame(8'h07, 1'b0, 8'h00, 1'b0, -1);
    chk_idle("after_07");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of each parallel word (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning shift order (1 = bit DATA_W-1 first; 0 = bit 0 first).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load_valid  input  1  upstream presents a word on load_data.
REQ-006 SHALL have port load_data  input  DATA_W  parallel word to serialize.
REQ-007 SHALL have port load_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port bit_out  output  1  serial bit, wired to the sequence detector data_in.
REQ-009 SHALL have port bit_valid  output  1  bit_out carries a frame bit this cycle.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse coincident with the last bit of a frame.
REQ-011 SHALL have port bit_index  output  $clog2(DATA_W+2)  zero-based position of the current bit within the frame.

Function
REQ-012 SHALL implement a two-state FSM: IDLE, SHIFT.
REQ-013 A word SHALL be accepted on any rising edge where load_valid and load_ready are both 1.
- load_ready = 1 in IDLE.
- load_ready = 1 in SHIFT only during the last bit cycle.
REQ-014 Accepted words SHALL be captured into an internal shift register.
- Upon acceptance the FSM SHALL enter SHIFT.
- First bit appears on bit_out in the cycle after acceptance (latency 1).
REQ-015 In SHIFT, exactly one bit SHALL be emitted per cycle with bit_valid = 1.
- Frame length FRAME_LEN = DATA_W, or DATA_W+1 with parity (REQ-023).
REQ-016 bit_index SHALL start at 0 and increment by 1 per emitted bit.
- frame_done = 1 when bit_index = FRAME_LEN-1.
REQ-017 If a word is accepted during the last bit cycle, the next frame SHALL start on the following cycle with no bubble: bit_valid stays 1 and bit_index returns to 0.
REQ-018 If no word is accepted during the last bit cycle, the FSM SHALL return to IDLE.
REQ-019 In IDLE, outputs SHALL be held: bit_out = 0, bit_valid = 0, frame_done = 0, bit_index = 0.
REQ-020 load_valid while load_ready = 0 SHALL be ignored without side effects; upstream holds load_data until accepted.
REQ-021 load_data SHALL be sampled only on acceptance; later changes SHALL not affect the frame in flight.

Reset
REQ-022 When reset is high at a rising edge, all state SHALL return to IDLE regardless of FSM state, aborting any frame mid-shift.
- Outputs after the edge: load_ready = 1, bit_out = 0, bit_valid = 0, frame_done = 0, bit_index = 0.
- A load_valid asserted during reset SHALL be ignored.

Configuration
REQ-023 Macro BIT_SERIALIZER_PARITY_EN, when defined, SHALL append one even-parity bit (XOR of all DATA_W data bits) after the data bits.
- FRAME_LEN = DATA_W+1.
- frame_done SHALL assert on the parity bit.
REQ-024 Without BIT_SERIALIZER_PARITY_EN, FRAME_LEN = DATA_W and no parity logic SHALL be present.

Structure
REQ-025 Shared package bit_serializer_pkg SHALL contain:
- the ser_state_t enum (IDLE, SHIFT), 1-bit encoding;
- the DATA_W default constant.
REQ-026 The bit-position counter SHALL be a sub-module, bit_counter.
- Inputs: clear, enable, terminal count.
- Output: wrap flag.
- The FSM and shift register SHALL stay in bit_serializer.

Verification
REQ-027 DATA_W=8, MSB_FIRST=1, single load of 8'hB4 -> bit_out 1,0,1,1,0,1,0,0 on cycles 1..8 after acceptance, bit_valid high for those 8 cycles, frame_done only on cycle 8, then IDLE.
REQ-028 Back-to-back 8'hB4 then 8'h0F, with the second presented during the last bit -> 16 consecutive bit_valid cycles, bit_index 0..7,0..7, frame_done pulses on cycles 8 and 16.
REQ-029 MSB_FIRST=0, load 8'h01 -> bit_out 1 then seven 0s; load_valid asserted mid-frame with 8'hFF is not accepted until the last bit cycle.
REQ-030 Reset asserted when bit_index = 3 of 8'hB4 -> the next cycle shows bit_valid = 0, bit_out = 0, load_ready = 1; a subsequent load of 8'h0F serializes cleanly from bit_index 0.
REQ-031 With BIT_SERIALIZER_PARITY_EN -> 8'hB4 emits a 9-bit frame with parity bit 0; 8'h07 emits parity bit 1; frame_done on the 9th bit.
REQ-032 Feeding bit_out/bit_valid into the downstream detector with a frame containing 1,0,1 -> the detector asserts its detect output once per occurrence.
